// File: rtl/alu_pkg.sv
// ALU opcode constants shared by decode and execute.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4;

endpackage

// File: rtl/ex_pkg.sv
// Execute-stage operand selects and the buffered result entry.
package ex_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        A_RS1  = 2'd0,
        A_PC   = 2'd1,
        A_ZERO = 2'd2
    } a_sel_e;

    typedef enum logic [1:0] {
        B_RS2  = 2'd0,
        B_IMM  = 2'd1,
        B_FOUR = 2'd2
    } b_sel_e;

    typedef struct packed {
        logic [XLEN-1:0]  result;
        logic [REG_W-1:0] rd;
        logic             we;
        logic             illegal;
    } entry_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: ADD/SUB/XOR/OR/AND modulo 2^N; unknown opcodes give 0 and flag illegal.
module alu
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [2:0]   alu_type,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result,
    output logic         illegal
);

    logic signed [N-1:0] sa;
    logic signed [N-1:0] sb;

    assign sa = signed'(a);
    assign sb = signed'(b);

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (alu_type)
            ALU_ADD: result = unsigned'(sa + sb);
            ALU_SUB: result = unsigned'(sa - sb);
            ALU_XOR: result = a ^ b;
            ALU_OR:  result = a | b;
            ALU_AND: result = a & b;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/sync_fifo2.sv
// Two-entry in-order FIFO of result entries; flush squashes everything, including same-cycle push/pop.
module sync_fifo2
    import ex_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    entry_t     mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       do_push;
    logic       do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Execute front end: operand select, ALU, and a 2-entry result buffer between decode and writeback.
module alu_issue_stage
    import ex_pkg::*;
#(
    parameter int N    = XLEN,
    parameter int RD_W = REG_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_alu_type,
    input  logic [1:0]      in_a_sel,
    input  logic [1:0]      in_b_sel,
    input  logic [N-1:0]    in_rs1,
    input  logic [N-1:0]    in_rs2,
    input  logic [N-1:0]    in_pc,
    input  logic [N-1:0]    in_imm,
    input  logic [RD_W-1:0] in_rd,
    input  logic            in_we,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_result,
    output logic [RD_W-1:0] out_rd,
    output logic            out_we,
    output logic            out_illegal
);

    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic         sel_illegal_a;
    logic         sel_illegal_b;
    logic [N-1:0] alu_result;
    logic         alu_illegal;
    entry_t       push_entry;
    entry_t       head;
    logic         full;
    logic         empty;

    // Operand selection; the reserved select encoding forces a zero operand and an illegal op.
    always_comb begin
        op_a          = '0;
        sel_illegal_a = 1'b0;
        case (a_sel_e'(in_a_sel))
            A_RS1:   op_a = in_rs1;
            A_PC:    op_a = in_pc;
            A_ZERO:  op_a = '0;
            default: sel_illegal_a = 1'b1;
        endcase
    end

    always_comb begin
        op_b          = '0;
        sel_illegal_b = 1'b0;
        case (b_sel_e'(in_b_sel))
            B_RS2:   op_b = in_rs2;
            B_IMM:   op_b = in_imm;
            B_FOUR:  op_b = N'(4);
            default: sel_illegal_b = 1'b1;
        endcase
    end

    alu #(.N(N)) u_alu (
        .alu_type (in_alu_type),
        .a        (op_a),
        .b        (op_b),
        .result   (alu_result),
        .illegal  (alu_illegal)
    );

    always_comb begin
        push_entry         = '0;
        push_entry.result  = alu_result;
        push_entry.rd      = in_rd;
        push_entry.we      = in_we;
        push_entry.illegal = alu_illegal || sel_illegal_a || sel_illegal_b;
    end

    // Result buffer boundary: ready depends only on buffer state and reset.
    assign in_ready = rst_n && !full;

    sync_fifo2 u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (in_valid && in_ready),
        .push_data (push_entry),
        .pop       (out_ready),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign out_valid   = !empty;
    assign out_result  = head.result;
    assign out_rd      = head.rd;
    assign out_we      = head.we;
    assign out_illegal = head.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: operand selects, ALU ops, buffering, flush and async reset.
module tb_alu_issue_stage;
    import alu_pkg::*;
    import ex_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_alu_type;
    logic [1:0]  in_a_sel;
    logic [1:0]  in_b_sel;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [31:0] in_pc;
    logic [31:0] in_imm;
    logic [4:0]  in_rd;
    logic        in_we;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_illegal;

    int checks;
    int failures;

    alu_issue_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_alu_type (in_alu_type),
        .in_a_sel    (in_a_sel),
        .in_b_sel    (in_b_sel),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_pc       (in_pc),
        .in_imm      (in_imm),
        .in_rd       (in_rd),
        .in_we       (in_we),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_we      (out_we),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] t, input logic [1:0] as, input logic [1:0] bs,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] p,
                         input logic [31:0] im, input logic [4:0] rd, input logic we);
        in_alu_type = t;
        in_a_sel    = as;
        in_b_sel    = bs;
        in_rs1      = r1;
        in_rs2      = r2;
        in_pc       = p;
        in_imm      = im;
        in_rd       = rd;
        in_we       = we;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(ALU_ADD, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        #3;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++;
        if ({out_result, out_rd, out_we, out_illegal} !== 39'd0) begin
            failures++; $display("FAIL reset_out_fields got=%h exp=0", {out_result, out_rd, out_we, out_illegal});
        end
        step(); step();
        rst_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_add();
        drive(ALU_ADD, A_RS1, B_RS2, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3, 1'b1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%0b exp=1", out_valid); end
        checks++;
        if ({out_result, out_rd, out_we, out_illegal} !== {32'd12, 5'd3, 1'b1, 1'b0}) begin
            failures++; $display("FAIL add_entry got=%h/%0d/%0b/%0b exp=c/3/1/0", out_result, out_rd, out_we, out_illegal);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL add_pop_valid got=%0b exp=0", out_valid); end
    endtask

    task automatic test_sub_pc();
        out_ready = 1'b1;
        drive(ALU_SUB, A_RS1, B_IMM, 32'd3, 32'd0, 32'd0, 32'd5, 5'd4, 1'b1);
        in_valid = 1'b1;
        step();
        checks++;
        if (out_result !== 32'hFFFF_FFFE || out_valid !== 1'b1) begin
            failures++; $display("FAIL sub_imm got=%h v=%0b exp=fffffffe v=1", out_result, out_valid);
        end
        drive(ALU_ADD, A_PC, B_FOUR, 32'd9, 32'd9, 32'h100, 32'd0, 5'd5, 1'b0);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_result !== 32'h104 || out_rd !== 5'd5 || out_we !== 1'b0 || out_valid !== 1'b1) begin
            failures++; $display("FAIL pc_four got=%h rd=%0d we=%0b v=%0b exp=104 rd=5 we=0 v=1", out_result, out_rd, out_we, out_valid);
        end
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL sub_pc_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(ALU_ADD, A_RS1, B_RS2, 32'd1, 32'd1, 32'd0, 32'd0, 5'd1, 1'b1);
        step();
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_one got=%0b exp=1", in_ready); end
        drive(ALU_XOR, A_RS1, B_RS2, 32'hF0, 32'hFF, 32'd0, 32'd0, 5'd2, 1'b1);
        step();
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_ready got=%0b exp=0", in_ready); end
        drive(ALU_OR, A_RS1, B_IMM, 32'h100, 32'd0, 32'd0, 32'h1, 5'd4, 1'b1);
        step();
        checks++;
        if (out_result !== 32'd2 || out_rd !== 5'd1 || in_ready !== 1'b0) begin
            failures++; $display("FAIL b2b_hold got=%h rd=%0d rdy=%0b exp=2 rd=1 rdy=0", out_result, out_rd, in_ready);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h0F || out_rd !== 5'd2 || in_ready !== 1'b1) begin
            failures++; $display("FAIL b2b_y got=%h rd=%0d v=%0b rdy=%0b exp=f rd=2 v=1 rdy=1", out_result, out_rd, out_valid, in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h101 || out_rd !== 5'd4) begin
            failures++; $display("FAIL b2b_z got=%h rd=%0d v=%0b exp=101 rd=4 v=1", out_result, out_rd, out_valid);
        end
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%0b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(ALU_AND, A_RS1, B_RS2, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 5'd6, 1'b1);
        step();
        checks++;
        if (out_result !== 32'hF000) begin failures++; $display("FAIL and_result got=%h exp=f000", out_result); end
        step();
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL flush_state got v=%0b rdy=%0b exp v=0 rdy=1", out_valid, in_ready);
        end
        drive(ALU_ADD, A_RS1, B_RS2, 32'd10, 32'd20, 32'd0, 32'd0, 5'd7, 1'b1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'd30 || out_rd !== 5'd7) begin
            failures++; $display("FAIL flush_after got=%h rd=%0d v=%0b exp=1e rd=7 v=1", out_result, out_rd, out_valid);
        end
        step();
        checks++;
        if (out_result !== 32'd30 || out_valid !== 1'b1) begin
            failures++; $display("FAIL flush_after_hold got=%h v=%0b exp=1e v=1", out_result, out_valid);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive(3'd7, A_RS1, B_RS2, 32'hFFFF, 32'hFFFF, 32'd0, 32'd0, 5'd9, 1'b1);
        step();
        checks++;
        if ({out_result, out_rd, out_we, out_illegal} !== {32'd0, 5'd9, 1'b1, 1'b1}) begin
            failures++; $display("FAIL illegal_type got=%h/%0d/%0b/%0b exp=0/9/1/1", out_result, out_rd, out_we, out_illegal);
        end
        drive(ALU_ADD, 2'd3, B_RS2, 32'd100, 32'd5, 32'd0, 32'd0, 5'd10, 1'b0);
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_result, out_rd, out_we, out_illegal} !== {32'd5, 5'd10, 1'b0, 1'b1}) begin
            failures++; $display("FAIL illegal_sel got=%h/%0d/%0b/%0b exp=5/10/0/1", out_result, out_rd, out_we, out_illegal);
        end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(ALU_ADD, A_ZERO, B_FOUR, 32'd0, 32'd0, 32'd0, 32'd0, 5'd11, 1'b1);
        step();
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++; $display("FAIL async_reset got v=%0b rdy=%0b exp v=0 rdy=0", out_valid, in_ready);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_release got rdy=%0b v=%0b exp rdy=1 v=0", in_ready, out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_idle got v=%0b exp=0", out_valid); end
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'd4) begin
            failures++; $display("FAIL reset_accept got=%h v=%0b exp=4 v=1", out_result, out_valid);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_add();
        test_sub_pc();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
